register: RTL and testbench

REGISTER -- requirements
Module: register

---
 rtl/register.sv | 53 +++++
 tb/tb_register.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module   : register
//  Purpose  : WIDTH-bit loadable storage register with an asynchronous,
//             active-low clear. The register is built from WIDTH identical,
//             independent bit cells. Each cell is a 2:1 hold/load select
//             followed by a D flip-flop with asynchronous clear.
//
//  Ports    : clk    - in  1      rising-edge clock
//             rst_n  - in  1      asynchronous active-low reset (clears out)
//             in     - in  WIDTH  signed data, sampled at the rising edge
//             load   - in  1      write enable, sampled at the rising edge
//             out    - out WIDTH  signed stored value, driven by the flops
//
//  Revision : 1.0 - initial release
// ============================================================================
module register #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    load,
    output logic signed [WIDTH-1:0] out
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_bit
            logic bit_d;
            logic bit_q;

            // A ternary is used rather than if/else so that an X on load
            // propagates into the cell instead of silently selecting hold.
            always_comb begin
                bit_d = load ? in[i] : bit_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bit_q <= 1'b0;
                end else begin
                    bit_q <= bit_d;
                end
            end

            // Output comes straight from the flop: no path from in/load.
            assign out[i] = bit_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register
//  Purpose  : Directed, self-checking bench for register. Expected values are
//             pushed to a scoreboard queue as stimulus is applied and popped
//             after the corresponding rising clock edge.
//
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register;

    localparam int WIDTH = 16;

    logic                    clk;
    logic                    rst_n;
    logic signed [WIDTH-1:0] tb_in;
    logic                    tb_load;
    logic signed [WIDTH-1:0] tb_out;

    logic [WIDTH-1:0]        exp_q[$];
    logic [WIDTH-1:0]        model;
    int                      tests;
    int                      fails;

    register #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (tb_in),
        .load  (tb_load),
        .out   (tb_out)
    );

    // 10 ns period, rising edges at 5, 15, 25 ... ns
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] expv);
        tests = tests + 1;
        assert (obs === expv)
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, record the expectation,
    // then compare just after the following rising edge.
    task automatic step(input string tag, input logic [WIDTH-1:0] d,
                        input logic l);
        logic [WIDTH-1:0] e;
        @(negedge clk);
        tb_in   = d;
        tb_load = l;
        if (l) model = d;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, tb_out, e);
    endtask

    initial begin
        logic [WIDTH-1:0] walk [6];
        tests   = 0;
        fails   = 0;
        model   = '0;
        rst_n   = 1'b0;
        tb_in   = '0;
        tb_load = 1'b0;

        // Reset state, and reset dominates load across a clock edge
        #2;
        check("reset_state", tb_out, 16'h0000);
        tb_in   = 16'h1234;
        tb_load = 1'b1;
        @(posedge clk);
        #1;
        check("reset_blocks_load", tb_out, 16'h0000);

        // Release reset between edges, then hold zero
        @(negedge clk);
        tb_load = 1'b0;
        tb_in   = '0;
        #2 rst_n = 1'b1;
        step("hold_zero_0", 16'h0000, 1'b0);
        step("hold_zero_1", 16'h0000, 1'b0);

        // Negative value stored bit-exact, then held
        step("neg_load", 16'h8285, 1'b1);           // -32123
        check("neg_value", tb_out, 16'(-32123));
        step("neg_hold", 16'd11111, 1'b0);

        // Hold versus load
        step("hold_12345", 16'd12345, 1'b0);
        step("load_12345", 16'd12345, 1'b1);

        // Power-of-two walk, each load followed by a hold with a different in
        walk = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd8, 16'd16};
        for (int k = 0; k < 6; k++) begin
            step($sformatf("walk_load_%0d", walk[k]), walk[k], 1'b1);
            step($sformatf("walk_hold_%0d", walk[k]), ~walk[k], 1'b0);
        end

        // Async reset mid-run; a pending load is armed and must be lost
        @(negedge clk);
        tb_in   = 16'd77;
        tb_load = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_clear", tb_out, 16'h0000);
        model   = '0;
        tb_load = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_pending_load", tb_out, 16'h0000);
        step("post_reset_hold_0", 16'hFFFF, 1'b0);
        step("post_reset_hold_1", 16'hA5A5, 1'b0);

        // Glitch immunity: only the value present at the edge is captured
        step("glitch_base", 16'h00F0, 1'b1);
        @(negedge clk);
        tb_load = 1'b1;
        tb_in   = 16'h1111;
        #1 tb_in = 16'h2222;
        #1 check("glitch_mid", tb_out, model);
        tb_in = 16'h3333;
        #1 tb_in = 16'hC3C3;
        model = 16'hC3C3;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        check("glitch_capture", tb_out, exp_q.pop_front());

        // A load pulse that ends before the edge must have no effect
        @(negedge clk);
        tb_load = 1'b1;
        tb_in   = 16'h5A5A;
        #2 tb_load = 1'b0;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        check("load_pulse_ignored", tb_out, exp_q.pop_front());

        check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the bench always terminates on its own
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
